// File: rtl/alarm_ctrl.sv
// alarm_ctrl: alarm-clock alarm controller on the 1 Hz divided clock.
//
// Holds an editable BCD alarm time and rings when the current time matches it.
// RING lasts RING_SECS cycles with a blinking indicator. A snooze request during
// RING parks the alarm in SNOOZE for SNOOZE_SECS cycles and then rings again, up
// to MAX_SNOOZE times per alarm event.
//
// Ports:
//   div_clk, rst_n                    1 Hz tick, asynchronous active-low reset
//   alarm_on, set_en                  alarm enable switch, alarm-edit mode (levels)
//   sel_pulse, inc_pulse              edit controls: next field, increment field
//   stop_pulse, snooze_pulse          cancel ringing/snooze, request snooze
//   hourH..secL                       current time, BCD digits
//   alarm_hourH..alarm_secL           stored alarm time, BCD digits, registered
//   field_sel                         field being edited: 0 hour, 1 minute, 2 second
//   ringing, snoozing                 FSM state flags
//   alarm_led                         active-low indicator (blinks while ringing)
module alarm_ctrl #(
    parameter int RING_SECS   = 10,
    parameter int SNOOZE_SECS = 60,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic       div_clk,
    input  logic       rst_n,
    input  logic       alarm_on,
    input  logic       set_en,
    input  logic       sel_pulse,
    input  logic       inc_pulse,
    input  logic       stop_pulse,
    input  logic       snooze_pulse,
    input  logic [3:0] hourH,
    input  logic [3:0] hourL,
    input  logic [3:0] minH,
    input  logic [3:0] minL,
    input  logic [3:0] secH,
    input  logic [3:0] secL,
    output logic [3:0] alarm_hourH,
    output logic [3:0] alarm_hourL,
    output logic [3:0] alarm_minH,
    output logic [3:0] alarm_minL,
    output logic [3:0] alarm_secH,
    output logic [3:0] alarm_secL,
    output logic [1:0] field_sel,
    output logic       ringing,
    output logic       snoozing,
    output logic       alarm_led
);

    // Widths cover the largest value each counter can hold; the guard keeps
    // MAX_SNOOZE = 0 from producing a zero-width vector.
    localparam int RW = $clog2(RING_SECS + 1);
    localparam int DW = $clog2(SNOOZE_SECS + 1);
    localparam int SW = (MAX_SNOOZE < 1) ? 1 : $clog2(MAX_SNOOZE + 1);

    localparam logic [RW-1:0] RING_LAST   = RW'(RING_SECS - 1);
    localparam logic [DW-1:0] SNOOZE_LOAD = DW'(SNOOZE_SECS - 1);
    localparam logic [SW-1:0] SNOOZE_MAX  = SW'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [RW-1:0] ring_cnt, ring_cnt_nx;
    logic [SW-1:0] snooze_cnt, snooze_cnt_nx;
    logic [DW-1:0] delay_cnt, delay_cnt_nx;
    logic          match;
    logic          abort_req;

    // Two-digit BCD increment that wraps to 00 after {hi_max, lo_max}.
    function automatic logic [7:0] bcd_inc(input logic [3:0] hi, input logic [3:0] lo,
                                           input logic [3:0] hi_max, input logic [3:0] lo_max);
        logic [7:0] r;
        if (hi == hi_max && lo == lo_max) begin
            r = 8'h00;
        end else if (lo == 4'd9) begin
            r = {hi + 4'd1, 4'd0};
        end else begin
            r = {hi, lo + 4'd1};
        end
        return r;
    endfunction

    // Alarm-time editing. The increment uses the field selected before this
    // cycle's sel_pulse takes effect; leaving edit mode returns to the hour field.
    always_ff @(posedge div_clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_hourH <= 4'd0;
            alarm_hourL <= 4'd7;
            alarm_minH  <= 4'd0;
            alarm_minL  <= 4'd0;
            alarm_secH  <= 4'd0;
            alarm_secL  <= 4'd0;
            field_sel   <= 2'd0;
        end else if (set_en) begin
            if (inc_pulse) begin
                case (field_sel)
                    2'd0:    {alarm_hourH, alarm_hourL} <= bcd_inc(alarm_hourH, alarm_hourL, 4'd2, 4'd3);
                    2'd1:    {alarm_minH, alarm_minL}   <= bcd_inc(alarm_minH, alarm_minL, 4'd5, 4'd9);
                    2'd2:    {alarm_secH, alarm_secL}   <= bcd_inc(alarm_secH, alarm_secL, 4'd5, 4'd9);
                    default: begin end
                endcase
            end
            if (sel_pulse) begin
                field_sel <= (field_sel == 2'd2) ? 2'd0 : field_sel + 2'd1;
            end
        end else begin
            field_sel <= 2'd0;
        end
    end

    // Match is suppressed while editing or disabled, so a half-edited alarm
    // time can never trigger.
    always_comb begin
        match = alarm_on && !set_en &&
                hourH == alarm_hourH && hourL == alarm_hourL &&
                minH  == alarm_minH  && minL  == alarm_minL  &&
                secH  == alarm_secH  && secL  == alarm_secL;
        abort_req = !alarm_on || set_en;
    end

    // State and counter registers.
    always_ff @(posedge div_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ring_cnt   <= '0;
            snooze_cnt <= '0;
            delay_cnt  <= '0;
        end else begin
            state      <= state_nx;
            ring_cnt   <= ring_cnt_nx;
            snooze_cnt <= snooze_cnt_nx;
            delay_cnt  <= delay_cnt_nx;
        end
    end

    // Next-state logic. Order of tests inside RING/SNOOZE encodes the priority:
    // disable/edit, then stop, then snooze, then timeout. A snooze request past
    // the limit falls through to the normal ring count.
    always_comb begin
        state_nx      = state;
        ring_cnt_nx   = ring_cnt;
        snooze_cnt_nx = snooze_cnt;
        delay_cnt_nx  = delay_cnt;
        case (state)
            IDLE: begin
                if (match) begin
                    state_nx      = RING;
                    ring_cnt_nx   = '0;
                    snooze_cnt_nx = '0;
                end
            end
            RING: begin
                if (abort_req || stop_pulse) begin
                    state_nx = IDLE;
                end else if (snooze_pulse && snooze_cnt < SNOOZE_MAX) begin
                    state_nx      = SNOOZE;
                    snooze_cnt_nx = snooze_cnt + SW'(1);
                    delay_cnt_nx  = SNOOZE_LOAD;
                end else if (ring_cnt == RING_LAST) begin
                    state_nx = IDLE;
                end else begin
                    ring_cnt_nx = ring_cnt + RW'(1);
                end
            end
            SNOOZE: begin
                if (abort_req || stop_pulse) begin
                    state_nx = IDLE;
                end else if (delay_cnt == '0) begin
                    state_nx    = RING;
                    ring_cnt_nx = '0;
                end else begin
                    delay_cnt_nx = delay_cnt - DW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state. The LED blink follows the ring
    // counter's LSB so it starts lit (low) on every entry into RING.
    always_comb begin
        ringing   = (state == RING);
        snoozing  = (state == SNOOZE);
        alarm_led = (state == RING) ? ring_cnt[0] : 1'b1;
    end

endmodule

// File: tb/tb_alarm_ctrl.sv
// tb_alarm_ctrl: self-checking bench for alarm_ctrl.
//
// A behavioural model (alarm time as plain hours/minutes/seconds integers, the
// alarm as a mode plus elapsed/remaining cycle counts) predicts every output
// each cycle. Directed scenarios cover editing, wrap, ringing, snoozing,
// priority and reset; a randomized phase follows.
module tb_alarm_ctrl;

    localparam int RING_SECS   = 10;
    localparam int SNOOZE_SECS = 60;
    localparam int MAX_SNOOZE  = 3;

    localparam int M_IDLE   = 0;
    localparam int M_RING   = 1;
    localparam int M_SNOOZE = 2;

    logic       div_clk;
    logic       rst_n;
    logic       alarm_on;
    logic       set_en;
    logic       sel_pulse;
    logic       inc_pulse;
    logic       stop_pulse;
    logic       snooze_pulse;
    logic [3:0] hourH, hourL, minH, minL, secH, secL;
    logic [3:0] alarm_hourH, alarm_hourL, alarm_minH, alarm_minL, alarm_secH, alarm_secL;
    logic [1:0] field_sel;
    logic       ringing;
    logic       snoozing;
    logic       alarm_led;

    int cur_h, cur_m, cur_s;
    int al_h, al_m, al_s, m_field;
    int m_mode, m_elapsed, m_snoozes, m_left;
    int n_checks;
    int n_pass;

    assign hourH = 4'(cur_h / 10);
    assign hourL = 4'(cur_h % 10);
    assign minH  = 4'(cur_m / 10);
    assign minL  = 4'(cur_m % 10);
    assign secH  = 4'(cur_s / 10);
    assign secL  = 4'(cur_s % 10);

    alarm_ctrl #(
        .RING_SECS  (RING_SECS),
        .SNOOZE_SECS(SNOOZE_SECS),
        .MAX_SNOOZE (MAX_SNOOZE)
    ) dut (
        .div_clk     (div_clk),
        .rst_n       (rst_n),
        .alarm_on    (alarm_on),
        .set_en      (set_en),
        .sel_pulse   (sel_pulse),
        .inc_pulse   (inc_pulse),
        .stop_pulse  (stop_pulse),
        .snooze_pulse(snooze_pulse),
        .hourH       (hourH),
        .hourL       (hourL),
        .minH        (minH),
        .minL        (minL),
        .secH        (secH),
        .secL        (secL),
        .alarm_hourH (alarm_hourH),
        .alarm_hourL (alarm_hourL),
        .alarm_minH  (alarm_minH),
        .alarm_minL  (alarm_minL),
        .alarm_secH  (alarm_secH),
        .alarm_secL  (alarm_secL),
        .field_sel   (field_sel),
        .ringing     (ringing),
        .snoozing    (snoozing),
        .alarm_led   (alarm_led)
    );

    initial begin
        div_clk = 1'b0;
        forever #5 div_clk = ~div_clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [31:0] bcd_time(input int h, input int m, input int s);
        return 32'((h / 10) * 1048576 + (h % 10) * 65536 + (m / 10) * 4096 +
                   (m % 10) * 256 + (s / 10) * 16 + (s % 10));
    endfunction

    function automatic logic [31:0] dut_alarm();
        return {8'h00, alarm_hourH, alarm_hourL, alarm_minH, alarm_minL, alarm_secH, alarm_secL};
    endfunction

    task automatic model_reset();
        al_h = 7; al_m = 0; al_s = 0;
        m_field = 0;
        m_mode = M_IDLE; m_elapsed = 0; m_snoozes = 0; m_left = 0;
    endtask

    // One clock edge of the reference behaviour, using the inputs as sampled.
    task automatic model_step();
        bit abort_now;
        bit hit;
        abort_now = !alarm_on || set_en;
        hit = alarm_on && !set_en && cur_h == al_h && cur_m == al_m && cur_s == al_s;
        case (m_mode)
            M_IDLE: begin
                if (hit) begin
                    m_mode = M_RING; m_elapsed = 0; m_snoozes = 0;
                end
            end
            M_RING: begin
                if (abort_now || stop_pulse) begin
                    m_mode = M_IDLE;
                end else if (snooze_pulse && m_snoozes < MAX_SNOOZE) begin
                    m_mode = M_SNOOZE; m_snoozes++; m_left = SNOOZE_SECS;
                end else begin
                    m_elapsed++;
                    if (m_elapsed == RING_SECS) m_mode = M_IDLE;
                end
            end
            default: begin
                if (abort_now || stop_pulse) begin
                    m_mode = M_IDLE;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_mode = M_RING; m_elapsed = 0;
                    end
                end
            end
        endcase
        if (set_en) begin
            if (inc_pulse) begin
                if (m_field == 0) al_h = (al_h + 1) % 24;
                else if (m_field == 1) al_m = (al_m + 1) % 60;
                else al_s = (al_s + 1) % 60;
            end
            if (sel_pulse) m_field = (m_field + 1) % 3;
        end else begin
            m_field = 0;
        end
    endtask

    task automatic check_all();
        checkOutput("alarm_time", dut_alarm(), bcd_time(al_h, al_m, al_s));
        checkOutput("field_sel", 32'(field_sel), 32'(m_field));
        checkOutput("ringing", 32'(ringing), 32'(m_mode == M_RING));
        checkOutput("snoozing", 32'(snoozing), 32'(m_mode == M_SNOOZE));
        checkOutput("alarm_led", 32'(alarm_led),
                    (m_mode == M_RING) ? 32'(m_elapsed % 2) : 32'd1);
    endtask

    // Drive one cycle of pulses (levels and time are already set), clock it,
    // advance the model and compare on the following falling edge.
    task automatic applyStimulus(input bit sel, input bit inc, input bit stop, input bit snz);
        sel_pulse    = sel;
        inc_pulse    = inc;
        stop_pulse   = stop;
        snooze_pulse = snz;
        @(posedge div_clk);
        model_step();
        @(negedge div_clk);
        sel_pulse    = 1'b0;
        inc_pulse    = 1'b0;
        stop_pulse   = 1'b0;
        snooze_pulse = 1'b0;
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge div_clk);
        @(negedge div_clk);
        rst_n = 1'b1;
        checkOutput("reset_alarm", dut_alarm(), 32'h070000);
        check_all();
    endtask

    task automatic tick_time();
        cur_s++;
        if (cur_s == 60) begin cur_s = 0; cur_m++; end
        if (cur_m == 60) begin cur_m = 0; cur_h++; end
        if (cur_h == 24) cur_h = 0;
    endtask

    task automatic set_time(input int h, input int m, input int s);
        cur_h = h; cur_m = m; cur_s = s;
    endtask

    // Enter RING by presenting the alarm time for one edge, then move away.
    task automatic start_ring();
        set_time(al_h, al_m, al_s);
        applyStimulus(0, 0, 0, 0);
        set_time(12, 34, 56);
        checkOutput("ring_start", 32'(ringing), 32'd1);
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        rst_n = 1'b0;
        alarm_on = 1'b0;
        set_en = 1'b0;
        sel_pulse = 1'b0;
        inc_pulse = 1'b0;
        stop_pulse = 1'b0;
        snooze_pulse = 1'b0;
        set_time(12, 0, 0);
        model_reset();
        #1;
        checkOutput("reset_async_led", 32'(alarm_led), 32'd1);
        do_reset();

        // Editing: 3 hour increments, next field, 2 minute increments.
        set_en = 1'b1;
        repeat (3) applyStimulus(0, 1, 0, 0);
        applyStimulus(1, 0, 0, 0);
        repeat (2) applyStimulus(0, 1, 0, 0);
        checkOutput("edit_time", dut_alarm(), 32'h100200);
        checkOutput("edit_field", 32'(field_sel), 32'd1);

        // Wrap behaviour of hour and minute fields.
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("field_wrap", 32'(field_sel), 32'd0);
        repeat (13) applyStimulus(0, 1, 0, 0);
        checkOutput("hour_23", dut_alarm() >> 16, 32'h23);
        applyStimulus(0, 1, 0, 0);
        checkOutput("hour_wrap", dut_alarm() >> 16, 32'h00);
        applyStimulus(1, 0, 0, 0);
        repeat (7) applyStimulus(0, 1, 0, 0);
        checkOutput("min_09", (dut_alarm() >> 8) & 32'hff, 32'h09);
        applyStimulus(0, 1, 0, 0);
        checkOutput("min_carry", (dut_alarm() >> 8) & 32'hff, 32'h10);
        repeat (49) applyStimulus(0, 1, 0, 0);
        checkOutput("min_59", (dut_alarm() >> 8) & 32'hff, 32'h59);
        applyStimulus(0, 1, 0, 0);
        checkOutput("min_wrap", (dut_alarm() >> 8) & 32'hff, 32'h00);
        applyStimulus(1, 1, 0, 0);
        checkOutput("sel_inc_same", dut_alarm(), 32'h000100);
        checkOutput("sel_inc_field", 32'(field_sel), 32'd2);
        applyStimulus(0, 1, 0, 0);
        checkOutput("sec_inc", dut_alarm(), 32'h000101);
        set_en = 1'b0;
        applyStimulus(0, 0, 0, 0);
        checkOutput("field_clear", 32'(field_sel), 32'd0);

        // Ring-out with blink at alarm 07:00:00.
        do_reset();
        alarm_on = 1'b1;
        set_time(6, 59, 59);
        applyStimulus(0, 0, 0, 0);
        checkOutput("pre_match", 32'(ringing), 32'd0);
        tick_time();
        applyStimulus(0, 0, 0, 0);
        for (int i = 0; i < RING_SECS; i++) begin
            if (i > 0) begin
                tick_time();
                applyStimulus(0, 0, 0, 0);
            end
            checkOutput("ring_blink", {30'd0, ringing, alarm_led}, {30'd0, 1'b1, 1'(i % 2)});
        end
        tick_time();
        applyStimulus(0, 0, 0, 0);
        checkOutput("ring_done", {30'd0, ringing, alarm_led}, 32'b01);

        // Three snoozes in ring cycle 3, each 60 cycles long; the fourth is ignored.
        start_ring();
        for (int k = 0; k < MAX_SNOOZE; k++) begin
            repeat (2) applyStimulus(0, 0, 0, 0);
            applyStimulus(0, 0, 0, 1);
            checkOutput("snooze_enter", {30'd0, snoozing, alarm_led}, 32'b11);
            repeat (SNOOZE_SECS - 1) applyStimulus(0, 0, 0, 0);
            checkOutput("snooze_hold", 32'(snoozing), 32'd1);
            applyStimulus(0, 0, 0, 0);
            checkOutput("snooze_wake", {30'd0, ringing, alarm_led}, 32'b10);
        end
        repeat (2) applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("snooze_ignored", {30'd0, ringing, snoozing}, 32'b10);
        repeat (6) applyStimulus(0, 0, 0, 0);
        checkOutput("ring_tail", 32'(ringing), 32'd1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("ring_out", 32'(ringing), 32'd0);

        // Stop beats snooze; disabling during snooze returns to idle.
        start_ring();
        applyStimulus(0, 0, 1, 1);
        checkOutput("stop_over_snooze", {30'd0, ringing, snoozing}, 32'b00);
        start_ring();
        applyStimulus(0, 0, 0, 1);
        repeat (5) applyStimulus(0, 0, 0, 0);
        alarm_on = 1'b0;
        applyStimulus(0, 0, 0, 0);
        checkOutput("off_in_snooze", 32'(snoozing), 32'd0);
        alarm_on = 1'b1;

        // Matching time is ignored while editing or disabled.
        set_en = 1'b1;
        set_time(al_h, al_m, al_s);
        applyStimulus(0, 0, 0, 0);
        checkOutput("no_ring_edit", 32'(ringing), 32'd0);
        set_en = 1'b0;
        alarm_on = 1'b0;
        applyStimulus(0, 0, 0, 0);
        checkOutput("no_ring_off", 32'(ringing), 32'd0);
        alarm_on = 1'b1;
        set_time(12, 34, 56);
        applyStimulus(0, 0, 0, 0);

        // Asynchronous reset in the middle of RING.
        start_ring();
        applyStimulus(0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_mid_ring", {29'd0, ringing, snoozing, alarm_led}, 32'b001);
        model_reset();
        @(negedge div_clk);
        rst_n = 1'b1;
        repeat (3) applyStimulus(0, 0, 0, 0);
        checkOutput("post_reset_idle", 32'(ringing), 32'd0);

        // Randomized phase.
        for (int c = 0; c < 3000; c++) begin
            int r;
            bit s_sel, s_inc, s_stop, s_snz;
            if (alarm_on) begin
                if ($urandom_range(0, 79) == 0) alarm_on = 1'b0;
            end else if ($urandom_range(0, 4) == 0) begin
                alarm_on = 1'b1;
            end
            if (!set_en) begin
                if ($urandom_range(0, 39) == 0) set_en = 1'b1;
            end else if ($urandom_range(0, 7) == 0) begin
                set_en = 1'b0;
            end
            r = int'($urandom_range(0, 9));
            if (r == 0) set_time(al_h, al_m, al_s);
            else if (r < 5) tick_time();
            else set_time(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)),
                          int'($urandom_range(0, 59)));
            s_sel  = ($urandom_range(0, 2) == 0);
            s_inc  = ($urandom_range(0, 2) == 0);
            s_stop = ($urandom_range(0, 39) == 0);
            s_snz  = ($urandom_range(0, 5) == 0);
            applyStimulus(s_sel, s_inc, s_stop, s_snz);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 Parameter RING_SECS, default 10: ring duration in div_clk cycles.
REQ-002 Parameter SNOOZE_SECS, default 60: snooze delay in div_clk cycles.
REQ-003 Parameter MAX_SNOOZE, default 3: snoozes allowed per alarm event.
REQ-004 div_clk  in  1  system tick, 1 Hz divided clock; all logic on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 alarm_on  in  1  alarm enable switch, level.
REQ-007 set_en  in  1  alarm-edit mode, level.
REQ-008 sel_pulse  in  1  single-cycle pulse; advance the edited field.
REQ-009 inc_pulse  in  1  single-cycle pulse; increment the edited field.
REQ-010 stop_pulse  in  1  single-cycle pulse; cancel ringing or snooze.
REQ-011 snooze_pulse  in  1  single-cycle pulse; request snooze.
REQ-012 hourH, hourL, minH, minL, secH, secL  in  4 each  current time, BCD.
REQ-013 alarm_hourH ... alarm_secL  out  4 each  stored alarm time, BCD, registered.
REQ-014 field_sel  out  2  edited field: 0 = hour, 1 = minute, 2 = second.
REQ-015 ringing  out  1  high while in RING.
REQ-016 snoozing  out  1  high while in SNOOZE.
REQ-017 alarm_led  out  1  active-low alarm indicator.

Function
REQ-018 Edit mode: inputs are used only while set_en = 1; sel_pulse and inc_pulse are ignored otherwise.
REQ-019 sel_pulse steps field_sel 0 -> 1 -> 2 -> 0; field_sel forced to 0 on any cycle with set_en = 0.
REQ-020 inc_pulse increments the selected field in BCD with wrap: hour 23 -> 00, minute 59 -> 00, second 59 -> 00; low digit 9 -> 0 carries into the high digit.
REQ-021 sel_pulse and inc_pulse in the same cycle: the increment applies to the current field, then field_sel advances.
REQ-022 match = (all six current digits equal the stored alarm digits) AND alarm_on AND NOT set_en; evaluated combinationally and sampled at the clock edge.
REQ-023 FSM states are IDLE, RING, SNOOZE; ringing and snoozing are decoded from the registered state.
REQ-024 IDLE -> RING on the edge where match = 1; ring_cnt cleared; snooze_cnt cleared.
REQ-025 RING: ring_cnt increments each cycle; alarm_led = 0 on the first RING cycle and toggles every cycle after that (blink).
REQ-026 RING -> IDLE when ring_cnt reaches RING_SECS-1 with no other event.
REQ-027 RING -> SNOOZE on snooze_pulse when snooze_cnt < MAX_SNOOZE; snooze_cnt += 1; delay counter loaded with SNOOZE_SECS-1.
REQ-028 A snooze_pulse received with snooze_cnt = MAX_SNOOZE is ignored.
REQ-029 SNOOZE: delay counter decrements each cycle; at 0 -> RING with ring_cnt cleared; alarm_led = 1 throughout.
REQ-030 Priority per cycle: alarm_on = 0 or set_en = 1 (-> IDLE) > stop_pulse (-> IDLE) > snooze_pulse > timeout.
REQ-031 match while in RING or SNOOZE is ignored.
REQ-032 In IDLE, alarm_led = 1.
REQ-033 Counter widths are sized by $clog2 of the parameters; no counter overflows for any legal parameter value.

Reset
REQ-034 When rst_n = 0: state = IDLE; alarm time = 07:00:00; field_sel = 0; alarm_led = 1; ringing = 0; snoozing = 0; all counters = 0.
REQ-035 Reset asserted mid-RING or mid-SNOOZE aborts immediately; no ringing after release until the next match.

Verification
REQ-036 Reset, then set_en = 1, 3 x inc_pulse, sel_pulse, 2 x inc_pulse -> alarm 10:02:00; field_sel = 1.
REQ-037 Hour field at 23, inc_pulse -> 00; minute field at 59, inc_pulse -> 00; minute 09, inc_pulse -> 10.
REQ-038 alarm_on = 1, time reaches 07:00:00 -> ringing = 1 on the next edge; alarm_led = 0,1,0,... for 10 cycles; then IDLE with alarm_led = 1.
REQ-039 snooze_pulse in RING cycle 3 -> SNOOZE for 60 cycles, then RING restarts; the 4th snooze_pulse is ignored and the alarm rings out.
REQ-040 stop_pulse and snooze_pulse in the same RING cycle -> IDLE; alarm_on dropped during SNOOZE -> IDLE on the next edge.
REQ-041 Time matches with set_en = 1 or alarm_on = 0 -> no ringing.
